fetch_pc_stage: RTL and testbench
=================================

Name: fetch_pc_stage

Overview:
Instruction-fetch stage that owns the program counter (PC) and issues word fetches to instruction memory.
It presents each fetched instruction, its PC and PC+4 to decode through a valid/ready handshake.
Downstream, id_pc_plus4 feeds the 32-bit branch-target adder (pc_plus4 + shifted offset).
The resulting target comes back to this stage on redirect_target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
PC_STEP, 4, sequential increment in bytes
NOP_INSTR, 32'h0000_0000, value driven on id_instr when no valid instruction is held

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request; level, held until imem_ack
imem_addr  output  32  fetch address; stable while imem_req=1
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
redirect_valid  input  1  branch/jump taken, one-cycle pulse
redirect_target  input  32  new PC when redirect_valid=1
id_valid  output  1  instruction held for decode
id_ready  input  1  decode accepts this cycle
id_instr  output  32  held instruction
id_pc  output  32  PC of held instruction
id_pc_plus4  output  32  id_pc + PC_STEP

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, imem_addr=RESET_PC.
  - id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0.
  - First imem_req=1 on the first cycle after rst_n deasserts.
- Reset mid-operation discards any outstanding fetch. Memory must tolerate a request dropped without ack.
- All outputs are registered. imem_addr always equals pc, or the old address while in FLUSH.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack without redirect: latch id_instr=imem_rdata, id_pc=pc, id_pc_plus4=pc+PC_STEP. Set id_valid=1, imem_req=0, go to HOLD.
- State HOLD:
  - imem_req=0.
  - On id_valid & id_ready: pc<=pc+PC_STEP, id_valid<=0, go to FETCH.
  - Minimum 2 cycles per instruction; no bypass.
- State FLUSH:
  - imem_req stays 1 on the old address until imem_ack. Returned data is discarded.
  - On ack: pc<=saved target, go to FETCH.
- Redirect (highest priority):
  - HOLD: pc<=redirect_target, id_valid<=0, id_instr<=NOP_INSTR, go to FETCH. If id_ready was high in the same cycle, the transfer still counts; decode squashes it.
  - FETCH with imem_ack in the same cycle: data discarded, pc<=redirect_target, stay FETCH. imem_req drops for 1 cycle, then re-asserts on the new address.
  - FETCH without ack: save target, go to FLUSH.
  - FLUSH: new redirect overwrites the saved target (latest wins).
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, with no flag.
- redirect_target[1:0] is forced to 2'b00 (see optional feature).

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with target[1:0]!=0 sets fetch_misalign=1 (sticky until reset) and enters state HALT.
  - HALT: imem_req=0, id_valid=0, all inputs ignored.
  - Misaligned target during FLUSH: the outstanding ack is still absorbed, then HALT.
- Undefined: no port, no HALT state; low bits silently cleared.

Decomposition:
- Shared package fetch_pkg:
  - state enum: FETCH, HOLD, FLUSH, HALT.
  - default constants for NOP_INSTR, RESET_PC and PC_STEP.
  - 32-bit word typedef.
- No sub-module required. The PC register and next-PC mux stay in this module.
- PC+PC_STEP is an inline add.

Test Plan:
- Reset then imem_ack 1 cycle after each req, id_ready=1 -> imem_addr 0x0,0x4,0x8. id_pc_plus4 = 0x4,0x8,0xC. One instruction every 2 cycles after ack.
- HOLD with id_ready=0 for 5 cycles -> id_valid, id_instr, id_pc stable; imem_req=0. PC advances only after id_ready=1.
- Fetch outstanding at 0x10, redirect to 0x100, ack 3 cycles later -> imem_addr holds 0x10 until ack, data not presented, next req at 0x100.
- Redirect to 0x200 then 0x300 during the same FLUSH -> next fetch at 0x300.
- Redirect to 0xFFFF_FFFC, then sequential -> next fetch 0x0000_0000.
- Redirect to 0x102:
  - with FETCH_MISALIGN_TRAP_EN: fetch_misalign=1, no further requests.
  - without it: fetch at 0x100.
- rst_n low while imem_req=1 -> outputs immediately at reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction-fetch PC stage.
package fetch_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  state_t;

  localparam state_t FETCH = 2'd0;
  localparam state_t HOLD  = 2'd1;
  localparam state_t FLUSH = 2'd2;
  localparam state_t HALT  = 2'd3;

  localparam word_t       DEF_RESET_PC  = 32'h0000_0000;
  localparam word_t       DEF_NOP_INSTR = 32'h0000_0000;
  localparam int unsigned DEF_PC_STEP   = 4;

endpackage

// File: rtl/fetch_pc_stage.sv
// rtl/fetch_pc_stage.sv - PC owner: issues word fetches and hands instructions to decode.
// Optional FETCH_MISALIGN_TRAP_EN adds fetch_misalign and a HALT state on misaligned redirects.
module fetch_pc_stage
  import fetch_pkg::*;
#(
  parameter word_t       RESET_PC  = DEF_RESET_PC,
  parameter int unsigned PC_STEP   = DEF_PC_STEP,
  parameter word_t       NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam word_t STEP = word_t'(PC_STEP);

  state_t state_q, state_d;
  word_t  pc_q, pc_d;
  word_t  target_q, target_d;
  word_t  addr_q, addr_d;
  word_t  instr_q, instr_d;
  word_t  idpc_q, idpc_d;
  word_t  idpc4_q, idpc4_d;
  logic   req_q, req_d;
  logic   valid_q, valid_d;
  logic   ack_v;
  word_t  tgt_in;

  // An ack only counts against a request the memory actually saw.
  assign ack_v = imem_ack & req_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  assign tgt_in = redirect_target;
`else
  assign tgt_in = redirect_target & 32'hFFFF_FFFC;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    idpc_d   = idpc_q;
    idpc4_d  = idpc4_q;
    req_d    = req_q;
    valid_d  = valid_q;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (req_q && !imem_ack) begin
            target_d = tgt_in;
            state_d  = FLUSH;
          end else begin
            // Either nothing outstanding (request straight away) or the ack
            // just closed the old request (drop for one cycle first).
            pc_d   = tgt_in;
            addr_d = tgt_in;
            req_d  = !ack_v;
          end
        end else if (ack_v) begin
          instr_d = imem_rdata;
          idpc_d  = pc_q;
          idpc4_d = pc_q + STEP;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end else begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end
      end
      HOLD: begin
        if (redirect_valid || id_ready) begin
          pc_d    = redirect_valid ? tgt_in : pc_q + STEP;
          addr_d  = pc_d;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (redirect_valid) begin
          target_d = tgt_in;
        end
        if (ack_v) begin
          pc_d    = redirect_valid ? tgt_in : target_q;
          addr_d  = pc_d;
          req_d   = 1'b0;
          state_d = FETCH;
        end
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d = trap_q;
    if (state_q != HALT && redirect_valid && (tgt_in[1:0] != 2'b00)) begin
      trap_d = 1'b1;
    end
    // A pending trap waits out any outstanding fetch in FLUSH, then halts.
    if (state_q != HALT && trap_d && state_d != FLUSH) begin
      state_d = HALT;
      req_d   = 1'b0;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      addr_q   <= RESET_PC;
      instr_q  <= NOP_INSTR;
      idpc_q   <= '0;
      idpc4_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      idpc_q   <= idpc_d;
      idpc4_q  <= idpc4_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
  assign fetch_misalign = trap_q;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign id_valid    = valid_q;
  assign id_instr    = instr_q;
  assign id_pc       = idpc_q;
  assign id_pc_plus4 = idpc4_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// tb/tb_fetch_pc_stage.sv - self-checking bench for fetch_pc_stage with a transaction-level PC model.
module tb_fetch_pc_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  fetch_pc_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign  (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    id_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic ack_now();
    imem_ack = 1'b1;
    imem_rdata = mem_word(imem_addr);
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic redirect_now(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_target = t;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %08h exp 0", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", id_valid); end
    checks++; if (id_instr !== NOP) begin errors++; $display("FAIL reset_instr got %08h exp %08h", id_instr, NOP); end
    checks++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc got %08h/%08h exp 0/0", id_pc, id_pc_plus4); end
    rst_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got %0h@%08h exp 1@0", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    apply_reset();
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = 32'(4 * k);
      checks++; if (imem_req !== 1'b1 || imem_addr !== e) begin errors++; $display("FAIL seq_req%0d got %0h@%08h exp 1@%08h", k, imem_req, imem_addr, e); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== e) begin errors++; $display("FAIL seq_wait%0d got %0h@%08h exp 1@%08h", k, imem_req, imem_addr, e); end
      ack_now();
      checks++; if (id_valid !== 1'b1 || id_pc !== e || id_pc_plus4 !== e + 32'd4) begin errors++; $display("FAIL seq_id%0d got v%0h %08h/%08h exp v1 %08h/%08h", k, id_valid, id_pc, id_pc_plus4, e, e + 32'd4); end
      checks++; if (id_instr !== mem_word(e) || imem_req !== 1'b0) begin errors++; $display("FAIL seq_instr%0d got %08h req%0h exp %08h req0", k, id_instr, imem_req, mem_word(e)); end
      tick();
      checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin errors++; $display("FAIL seq_accept%0d got v%0h %08h exp v0 %08h", k, id_valid, id_instr, NOP); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    apply_reset();
    ack_now();
    held = mem_word(32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (id_valid !== 1'b1 || id_instr !== held || id_pc !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL stall%0d got v%0h %08h pc%08h req%0h exp v1 %08h pc0 req0", i, id_valid, id_instr, id_pc, imem_req, held); end
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL stall_release got v%0h req%0h@%08h exp v0 req1@4", id_valid, imem_req, imem_addr); end
  endtask

  task automatic test_ack_redirect();
    apply_reset();
    imem_ack = 1'b1;
    imem_rdata = mem_word(imem_addr);
    redirect_now(32'h40);
    imem_ack = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL ackredir_drop got v%0h req%0h exp v0 req0", id_valid, imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL ackredir_req got %0h@%08h exp 1@40", imem_req, imem_addr); end
  endtask

  task automatic test_flush();
    apply_reset();
    ack_now();
    redirect_now(32'h10);
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL hold_redir got v%0h %08h req%0h@%08h exp v0 NOP req1@10", id_valid, id_instr, imem_req, imem_addr); end
    redirect_now(32'h100);
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL flush_hold%0d got %0h@%08h exp 1@10", i, imem_req, imem_addr); end
      tick();
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL flush_discard got v%0h req%0h exp v0 req0", id_valid, imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL flush_next got %0h@%08h exp 1@100", imem_req, imem_addr); end
    ack_now();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== mem_word(32'h100)) begin errors++; $display("FAIL flush_data got v%0h %08h %08h exp v1 100 %08h", id_valid, id_pc, id_instr, mem_word(32'h100)); end
  endtask

  task automatic test_latest_wins();
    apply_reset();
    redirect_now(32'h200);
    redirect_now(32'h300);
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL latest_hold got %0h@%08h exp 1@0", imem_req, imem_addr); end
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL latest_next got %0h@%08h exp 1@300", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    apply_reset();
    ack_now();
    redirect_now(32'hFFFF_FFFC);
    ack_now();
    checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_id got %08h/%08h exp fffffffc/0", id_pc, id_pc_plus4); end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %0h@%08h exp 1@0", imem_req, imem_addr); end
  endtask

  task automatic test_misalign();
    apply_reset();
    ack_now();
    redirect_now(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL trap_enter got m%0h req%0h v%0h exp m1 req0 v0", fetch_misalign, imem_req, id_valid); end
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      id_ready = 1'($urandom_range(0, 1));
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_target = 32'h400;
      tick();
      checks++; if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL trap_halt%0d got m%0h req%0h v%0h exp m1 req0 v0", i, fetch_misalign, imem_req, id_valid); end
    end
    idle_inputs();
`else
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL misalign_clear got %0h@%08h exp 1@100", imem_req, imem_addr); end
    ack_now();
    checks++; if (id_pc !== 32'h100 || id_pc_plus4 !== 32'h104) begin errors++; $display("FAIL misalign_id got %08h/%08h exp 100/104", id_pc, id_pc_plus4); end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ack_now();
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rstmid_id got v%0h %08h %08h/%08h exp v0 NOP 0/0", id_valid, id_instr, id_pc, id_pc_plus4); end
    tick();
    rst_n = 1'b1;
    tick();
    redirect_now(32'h80);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_req got %0h@%08h exp 0@0", imem_req, imem_addr); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_addr, tgt;
    logic        prev_req, prev_valid, ack_given, rv, rdy;
    int          wait_cnt, lat, accepts;
    apply_reset();
    exp_pc = 32'h0;
    wait_cnt = 0;
    lat = $urandom_range(0, 3);
    accepts = 0;
    for (int c = 0; c < 1500; c++) begin
      prev_req = imem_req;
      prev_addr = imem_addr;
      prev_valid = id_valid;
      rdy = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 15) == 0);
      tgt = $urandom() & 32'hFFFF_FFFC;
      ack_given = imem_req && (wait_cnt >= lat);
      id_ready = rdy;
      redirect_valid = rv;
      redirect_target = tgt;
      imem_ack = ack_given;
      imem_rdata = ack_given ? mem_word(imem_addr) : $urandom();
      tick();
      if (ack_given) begin
        wait_cnt = 0;
        lat = $urandom_range(0, 3);
      end else if (prev_req) begin
        wait_cnt++;
      end
      if (prev_req && !ack_given) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin errors++; $display("FAIL rnd_stable c%0d got %0h@%08h exp 1@%08h", c, imem_req, imem_addr, prev_addr); end
      end
      if (rv) begin
        exp_pc = tgt;
      end else if (prev_valid && rdy) begin
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
      if (id_valid) begin
        checks++; if (id_pc !== exp_pc || id_pc_plus4 !== exp_pc + 32'd4 || id_instr !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_id c%0d got %08h/%08h %08h exp %08h/%08h %08h", c, id_pc, id_pc_plus4, id_instr, exp_pc, exp_pc + 32'd4, mem_word(exp_pc)); end
      end
    end
    idle_inputs();
    checks++; if (accepts < 50) begin errors++; $display("FAIL rnd_progress got %0d accepts exp >= 50", accepts); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_ack_redirect();
    test_flush();
    test_latest_wins();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
